ex_m_stage_elastic: RTL

Parametrised, elastic successor to the fixed EX→M pipeline register. It carries the ALU result, the store data, the branch target, the Rd/Rb indices and a generic control-bit vector from EX to MEM. It adds a valid/ready handshake, a 2-entry skid buffer for stall absorption, a flush, bubble gating of control bits, and saturating stall/squash counters. It sits between the EX stage and the MEM stage; a downstream stall no longer requires a combinational ready path back into EX.

---
 rtl/ex_m_stage_elastic.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_m_stage_elastic.sv
// ex_m_stage_elastic: elastic EX->MEM pipeline register with a 2-entry skid
// buffer, flush, bubble gating of control bits and saturating stall/squash
// counters. All state changes on the falling edge of CLK.
module ex_m_stage_elastic #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CTRL_W = 6,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              Resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_busB,
   input  logic [DATA_W-1:0] in_target,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [REG_W-1:0]  in_rb,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_busB,
   output logic [DATA_W-1:0] out_target,
   output logic [REG_W-1:0]  out_rd,
   output logic [REG_W-1:0]  out_rb,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  squash_cnt
);

   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] busB;
      logic [DATA_W-1:0] target;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  rb;
   } entry_t;

   entry_t            main_q, main_d;
   entry_t            skid_q, skid_d;
   entry_t            in_entry_c;
   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              in_ready_d;
   logic [CTRL_W-1:0] out_ctrl_d;
   logic [1:0]        occ_d;
   logic [CNT_W-1:0]  stall_d, squash_d;
   logic              accept_c, pop_c;
   logic [1:0]        held_c;
   logic [SUM_W-1:0]  squash_sum_c;

   // Input payload bundle, handshake qualifiers and squash arithmetic
   assign in_entry_c   = '{ctrl: in_ctrl, alu: in_alu, busB: in_busB,
                           target: in_target, rd: in_rd, rb: in_rb};
   assign accept_c     = in_valid & in_ready;
   assign pop_c        = main_valid_q & out_ready;
   assign held_c       = 2'(main_valid_q) + 2'(skid_valid_q);
   assign squash_sum_c = SUM_W'(squash_cnt) + SUM_W'(held_c);

   // Head entry drives the data outputs directly; data is never gated
   assign out_valid  = main_valid_q;
   assign out_alu    = main_q.alu;
   assign out_busB   = main_q.busB;
   assign out_target = main_q.target;
   assign out_rd     = main_q.rd;
   assign out_rb     = main_q.rb;

   // Next-state: flush beats pop/accept; skid drains into main before new input
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      stall_d      = stall_cnt;
      squash_d     = squash_cnt;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         if (squash_sum_c > SUM_W'(CNT_MAX)) begin
            squash_d = CNT_MAX;
         end else begin
            squash_d = CNT_W'(squash_sum_c);
         end
      end else begin
         if (main_valid_q) begin
            if (pop_c) begin
               if (skid_valid_q) begin
                  main_d       = skid_q;
                  skid_valid_d = 1'b0;
               end else if (accept_c) begin
                  main_d = in_entry_c;
               end else begin
                  main_valid_d = 1'b0;
               end
            end else if (accept_c) begin
               skid_d       = in_entry_c;
               skid_valid_d = 1'b1;
            end
         end else if (accept_c) begin
            main_d       = in_entry_c;
            main_valid_d = 1'b1;
         end

         if (main_valid_q && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_d = stall_cnt + CNT_W'(1);
         end
      end

      in_ready_d = !skid_valid_d;
      out_ctrl_d = main_valid_d ? main_d.ctrl : '0;
      occ_d      = 2'(main_valid_d) + 2'(skid_valid_d);
   end

   // State and registered outputs, falling-edge clocked with async clear
   always_ff @(negedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready     <= 1'b1;
         out_ctrl     <= '0;
         occ          <= 2'd0;
         stall_cnt    <= '0;
         squash_cnt   <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready     <= in_ready_d;
         out_ctrl     <= out_ctrl_d;
         occ          <= occ_d;
         stall_cnt    <= stall_d;
         squash_cnt   <= squash_d;
      end
   end

endmodule
